// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encodings, IR field positions and default widths.
package sisc_pkg;

  localparam int AW_DEF = 16;
  localparam int IW_DEF = 32;

  typedef enum logic [3:0] {
    NOOP   = 4'd0,
    LOD    = 4'd1,
    STR    = 4'd2,
    SWP    = 4'd3,
    BRA    = 4'd4,
    BRR    = 4'd5,
    BNE    = 4'd6,
    BNR    = 4'd7,
    ALU_OP = 4'd8,
    HLT    = 4'd15
  } opcode_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 20;
  localparam int RS_MSB  = 19;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 12;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluator: compares the status flags against the mm mask
// for the conditional branch opcodes.
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       br_taken
);

  logic any_match;

  assign any_match = |(stat & mm);

  always_comb begin
    br_taken = 1'b0;
    case (opcode_e'(opcode))
      BRA, BRR: br_taken = any_match;
      BNE, BNR: br_taken = ~any_match;
      default:  br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch / PC unit: PC, IR, halt flag, branch target selection.
// Optional retired-fetch counter built only when SISC_ICOUNT_EN is defined.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          ir_load,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic [3:0]    stat,
  input  logic [IW-1:0] im_data,
  output logic [AW-1:0] im_addr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    rd,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [15:0]   imm,
  output logic          br_taken,
  output logic          halted,
  output logic [31:0]   icount
);

  logic [AW-1:0]        pc;
  logic [IW-1:0]        ir;
  logic signed [15:0]   imm_s;
  logic signed [AW-1:0] imm_sx;
  logic [AW-1:0]        target;
  logic [AW-1:0]        pc_next;
  logic                 ir_accept;
  logic                 pc_accept;

  assign opcode  = ir[OP_MSB:OP_LSB];
  assign mm      = ir[MM_MSB:MM_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs      = ir[RS_MSB:RS_LSB];
  assign rt      = ir[RT_MSB:RT_LSB];
  assign imm     = ir[IMM_MSB:IMM_LSB];
  assign im_addr = pc;

  assign ir_accept = ir_load  & ~halted;
  assign pc_accept = pc_write & ~halted;

  sisc_br_cond u_br_cond (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .br_taken (br_taken)
  );

  // Relative offsets are signed and wrap modulo 2^AW.
  assign imm_s  = signed'(imm);
  assign imm_sx = AW'(imm_s);
  assign target = br_sel ? AW'(imm) : pc + $unsigned(imm_sx);

  always_comb begin
    pc_next = pc;
    if (!pc_sel)
      pc_next = pc + AW'(1);
    else if (br_taken)
      pc_next = target;
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      if (pc_accept)
        pc <= pc_next;
      if (ir_accept)
        ir <= im_data;
      if (opcode_e'(opcode) == HLT)
        halted <= 1'b1;
    end
  end

`ifdef SISC_ICOUNT_EN
  logic [31:0] icount_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      icount_q <= '0;
    else if (ir_accept && (icount_q != 32'hFFFF_FFFF))
      icount_q <= icount_q + 32'd1;
  end

  assign icount = icount_q;
`else
  assign icount = 32'd0;
`endif

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed self-checking bench for sisc_fetch with hand-computed expectations.
module tb_sisc_fetch;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic [3:0]  stat;
  logic [31:0] im_data;
  logic [15:0] im_addr;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [15:0] imm;
  logic        br_taken;
  logic        halted;
  logic [31:0] icount;

  int n_tests;
  int n_fail;

  sisc_fetch dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .stat     (stat),
    .im_data  (im_data),
    .im_addr  (im_addr),
    .opcode   (opcode),
    .mm       (mm),
    .rd       (rd),
    .rs       (rs),
    .rt       (rt),
    .imm      (imm),
    .br_taken (br_taken),
    .halted   (halted),
    .icount   (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] val);
    im_data = val;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
  endtask

  // Force the PC through an always-taken absolute BRA (mm=F, stat=F).
  task automatic set_pc(input logic [15:0] addr);
    load_ir({16'h4F00, addr});
    stat     = 4'hF;
    pc_sel   = 1'b1;
    br_sel   = 1'b1;
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
  endtask

  task automatic pc_step(input logic sel, input logic bsel);
    pc_sel   = sel;
    br_sel   = bsel;
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
  endtask

  logic [31:0] icount_exp;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_f    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    stat     = 4'h0;
    im_data  = 32'h0;
`ifdef SISC_ICOUNT_EN
    icount_exp = 32'd3;
`else
    icount_exp = 32'd0;
`endif

    #3;
    check("rst_pc", 32'(im_addr), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_br", 32'(br_taken), 32'h0);
    check("rst_icount", icount, 32'h0);
    tick();
    rst_f = 1'b1;

    // Some activity, then an asynchronous mid-cycle reset.
    im_data  = 32'h8123_4567;
    ir_load  = 1'b1;
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    tick();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    check("pre_rst_pc", 32'(im_addr), 32'h1);
    check("pre_rst_imm", 32'(imm), 32'h4567);
    #2;
    rst_f = 1'b0;
    #1;
    check("async_rst_pc", 32'(im_addr), 32'h0);
    check("async_rst_imm", 32'(imm), 32'h0);
    check("async_rst_op", 32'(opcode), 32'h0);
    rst_f = 1'b1;

    // Fetch after reset.
    im_data  = 32'h1234_0005;
    ir_load  = 1'b1;
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    tick();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    check("fetch_opcode", 32'(opcode), 32'h1);
    check("fetch_mm", 32'(mm), 32'h2);
    check("fetch_rd", 32'(rd), 32'h3);
    check("fetch_rs", 32'(rs), 32'h4);
    check("fetch_rt", 32'(rt), 32'h0);
    check("fetch_imm", 32'(imm), 32'h0005);
    check("fetch_pc", 32'(im_addr), 32'h1);

    // BRA absolute, not taken then taken.
    set_pc(16'h0040);
    check("set_pc", 32'(im_addr), 32'h0040);
    load_ir(32'h4100_0020);
    stat = 4'b0000;
    #1;
    check("bra_nt_br", 32'(br_taken), 32'h0);
    pc_step(1'b1, 1'b1);
    check("bra_nt_pc", 32'(im_addr), 32'h0040);
    stat = 4'b0001;
    #1;
    check("bra_t_br", 32'(br_taken), 32'h1);
    pc_step(1'b1, 1'b1);
    check("bra_t_pc", 32'(im_addr), 32'h0020);

    // BNE inverts the match; non-branch opcodes never take.
    load_ir(32'h6300_0000);
    stat = 4'b0010;
    #1;
    check("bne_match", 32'(br_taken), 32'h0);
    stat = 4'b0100;
    #1;
    check("bne_nomatch", 32'(br_taken), 32'h1);
    load_ir(32'h8F00_0000);
    stat = 4'hF;
    #1;
    check("alu_br", 32'(br_taken), 32'h0);

    // Relative BNR backwards.
    set_pc(16'h0010);
    load_ir(32'h7100_FFFC);
    stat = 4'b0000;
    pc_step(1'b1, 1'b0);
    check("bnr_back_pc", 32'(im_addr), 32'h000C);

    // Sequential wrap.
    set_pc(16'hFFFF);
    pc_step(1'b0, 1'b0);
    check("seq_wrap_pc", 32'(im_addr), 32'h0000);

    // Relative wrap with BRR.
    set_pc(16'hFFFE);
    load_ir(32'h5100_0004);
    stat = 4'b0001;
    pc_step(1'b1, 1'b0);
    check("rel_wrap_pc", 32'(im_addr), 32'h0002);

    // Halt and counter: 3 accepted loads, the third being HLT.
    rst_f = 1'b0;
    #1;
    rst_f = 1'b1;
    pc_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      im_data  = (i == 2) ? 32'hF000_0000 : 32'h0000_0000;
      ir_load  = 1'b1;
      pc_write = 1'b1;
      tick();
    end
    ir_load  = 1'b0;
    pc_write = 1'b0;
    check("hlt_in_ir_halted", 32'(halted), 32'h0);
    check("hlt_opcode", 32'(opcode), 32'hF);
    tick();
    check("halted_rise", 32'(halted), 32'h1);
    im_data  = 32'h1111_1111;
    ir_load  = 1'b1;
    pc_write = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    check("halt_pc_frozen", 32'(im_addr), 32'h3);
    check("halt_ir_frozen", {opcode, mm, rd, rs, imm}, {4'hF, 4'h0, 4'h0, 4'h0, 16'h0});
    check("halt_sticky", 32'(halted), 32'h1);
    check("icount", icount, icount_exp);

    rst_f = 1'b0;
    #1;
    check("rst_clear_halt", 32'(halted), 32'h0);
    check("rst_clear_icount", icount, 32'h0);
    rst_f = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
